// File: rtl/dvp_pkg.sv
// Shared types and helpers for the DVP sensor-side transmitter.
package dvp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } state_e;

    typedef enum logic {
        MODE_RAW10  = 1'b0,
        MODE_RGB565 = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        PAT_HRAMP = 2'd0,
        PAT_VRAMP = 2'd1,
        PAT_BARS  = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_e;

    // Grey ramp in RGB565: g[7:3] on R and B, g[7:2] on G; takes g[7:2] only.
    function automatic logic [15:0] rgb565_ramp(input logic [5:0] g_hi);
        return {g_hi[5:1], g_hi, g_hi[5:1]};
    endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Combinational pattern source: (x, y, pattern, mode, byte select) -> 10-bit DVP word.
module dvp_pattern_gen
    import dvp_pkg::*;
#(
    parameter int H_RES = 640,
    parameter int XW    = 11,
    parameter int YW    = 10
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  pattern_e      pattern,
    input  mode_e         mode,
    input  logic          byte_sel,
    input  logic [15:0]   solid,
    output logic [9:0]    word
);

    localparam int BAR_W = H_RES / 8;

    logic [9:0]  x10;
    logic [9:0]  y10;
    logic [2:0]  bar;
    logic [9:0]  raw;
    logic [15:0] pix565;

    always_comb begin
        x10    = 10'(x);
        y10    = 10'(y);
        bar    = 3'(x / XW'(BAR_W));
        raw    = '0;
        pix565 = '0;
        case (pattern)
            PAT_HRAMP: begin
                raw    = x10;
                pix565 = rgb565_ramp(x10[7:2]);
            end
            PAT_VRAMP: begin
                raw    = y10;
                pix565 = rgb565_ramp(y10[7:2]);
            end
            PAT_BARS: begin
                raw    = {bar, 7'h00};
                pix565 = {{5{bar[2]}}, {6{bar[1]}}, {5{bar[0]}}};
            end
            default: begin
                raw    = solid[9:0];
                pix565 = solid;
            end
        endcase

        if (mode == MODE_RGB565)
            word = byte_sel ? {pix565[7:0], 2'b00} : {pix565[15:8], 2'b00};
        else
            word = raw;
    end

endmodule

// File: rtl/dvp_sensor_tx.sv
// DVP camera-sensor emulator: frame timing FSM, counters and registered VSYNC/HREF/PIXDATA.
module dvp_sensor_tx
    import dvp_pkg::*;
#(
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int H_BLANK  = 160,
    parameter int VS_LINES = 3,
    parameter int V_BACK   = 17,
    parameter int V_FRONT  = 10
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_en,
    input  logic        I_mode,
    input  logic [1:0]  I_pattern,
    input  logic [15:0] I_solid,
    output logic        O_vsync,
    output logic        O_href,
    output logic [9:0]  O_pixdata,
    output logic [15:0] O_frame_cnt,
    output logic        O_busy
);

    localparam int HW    = $clog2(2 * H_RES + H_BLANK + 1);
    localparam int VM_A  = (VS_LINES > V_BACK) ? VS_LINES : V_BACK;
    localparam int VM_B  = (V_RES > V_FRONT) ? V_RES : V_FRONT;
    localparam int V_MAX = (VM_A > VM_B) ? VM_A : VM_B;
    localparam int VW    = $clog2(V_MAX + 1);

    state_e      state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    mode_e       mode_q;
    pattern_e    pat_q;
    logic [15:0] frame_cnt_q;
    logic        start;

    logic [HW-1:0] h_act;
    logic [HW-1:0] l_last;
    logic [VW-1:0] lines_m1;
    logic          line_end;
    logic          last_line;
    logic          href_c;
    logic [HW-1:0] pix_x;
    logic          byte_sel;
    logic [9:0]    pg_word;

    always_comb begin
        h_act    = (mode_q == MODE_RGB565) ? HW'(2 * H_RES) : HW'(H_RES);
        l_last   = h_act + HW'(H_BLANK - 1);
        line_end = (hcnt_q == l_last);
        case (state_q)
            VSYNC:   lines_m1 = VW'(VS_LINES - 1);
            VBACK:   lines_m1 = VW'(V_BACK - 1);
            ACTIVE:  lines_m1 = VW'(V_RES - 1);
            VFRONT:  lines_m1 = VW'(V_FRONT - 1);
            default: lines_m1 = '0;
        endcase
        last_line = line_end && (vcnt_q == lines_m1);
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        start   = 1'b0;
        if (state_q == IDLE) begin
            if (I_en) begin
                state_d = VSYNC;
                start   = 1'b1;
            end
        end else begin
            hcnt_d = line_end ? '0 : hcnt_q + 1'b1;
            if (line_end)
                vcnt_d = last_line ? '0 : vcnt_q + 1'b1;
            if (last_line) begin
                case (state_q)
                    VSYNC:  state_d = (V_BACK > 0) ? VBACK : ACTIVE;
                    VBACK:  state_d = ACTIVE;
                    ACTIVE: begin
                        if (V_FRONT > 0) begin
                            state_d = VFRONT;
                        end else begin
                            state_d = I_en ? VSYNC : IDLE;
                            start   = I_en;
                        end
                    end
                    VFRONT: begin
                        state_d = I_en ? VSYNC : IDLE;
                        start   = I_en;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q     <= IDLE;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            mode_q      <= MODE_RAW10;
            pat_q       <= PAT_HRAMP;
            frame_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            if (start) begin
                mode_q      <= mode_e'(I_mode);
                pat_q       <= pattern_e'(I_pattern);
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    // In RGB565 two line cycles share one pixel; even cycle carries the high byte.
    always_comb begin
        pix_x    = (mode_q == MODE_RGB565) ? {1'b0, hcnt_q[HW-1:1]} : hcnt_q;
        byte_sel = (mode_q == MODE_RGB565) && hcnt_q[0];
        href_c   = (state_q == ACTIVE) && (hcnt_q < h_act);
    end

    dvp_pattern_gen #(
        .H_RES (H_RES),
        .XW    (HW),
        .YW    (VW)
    ) u_pattern_gen (
        .x        (pix_x),
        .y        (vcnt_q),
        .pattern  (pat_q),
        .mode     (mode_q),
        .byte_sel (byte_sel),
        .solid    (I_solid),
        .word     (pg_word)
    );

    // Output stage trails the state register by one cycle so every output is a flop.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            O_vsync     <= 1'b0;
            O_href      <= 1'b0;
            O_pixdata   <= '0;
            O_frame_cnt <= '0;
            O_busy      <= 1'b0;
        end else begin
            O_vsync     <= (state_q == VSYNC);
            O_href      <= href_c;
            O_pixdata   <= href_c ? pg_word : '0;
            O_frame_cnt <= frame_cnt_q;
            O_busy      <= (state_q != IDLE);
        end
    end

endmodule

// File: tb/tb_dvp_sensor_tx.sv
// Directed self-checking bench for dvp_sensor_tx with small frame geometry.
module tb_dvp_sensor_tx;

    logic        I_clk;
    logic        I_rst;
    logic        I_en;
    logic        I_mode;
    logic [1:0]  I_pattern;
    logic [15:0] I_solid;
    logic        O_vsync, O_href, O_busy;
    logic [9:0]  O_pixdata;
    logic [15:0] O_frame_cnt;
    logic        vsync16, href16, busy16;
    logic [9:0]  pix16;
    logic [15:0] fcnt16;

    int compared = 0;
    int mismatched = 0;

    logic        v_s [0:299];
    logic        h_s [0:299];
    logic        b_s [0:299];
    logic [9:0]  p_s [0:299];
    logic [15:0] f_s [0:299];
    logic [9:0]  p16_s [0:299];

    dvp_sensor_tx #(
        .H_RES (8), .V_RES (4), .H_BLANK (4),
        .VS_LINES (1), .V_BACK (1), .V_FRONT (1)
    ) dut (
        .I_clk (I_clk), .I_rst (I_rst), .I_en (I_en), .I_mode (I_mode),
        .I_pattern (I_pattern), .I_solid (I_solid),
        .O_vsync (O_vsync), .O_href (O_href), .O_pixdata (O_pixdata),
        .O_frame_cnt (O_frame_cnt), .O_busy (O_busy)
    );

    dvp_sensor_tx #(
        .H_RES (16), .V_RES (4), .H_BLANK (4),
        .VS_LINES (1), .V_BACK (1), .V_FRONT (1)
    ) dut16 (
        .I_clk (I_clk), .I_rst (I_rst), .I_en (I_en), .I_mode (I_mode),
        .I_pattern (I_pattern), .I_solid (I_solid),
        .O_vsync (vsync16), .O_href (href16), .O_pixdata (pix16),
        .O_frame_cnt (fcnt16), .O_busy (busy16)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sample 0 is the edge that samples I_en; I_en drops after sample drop_at.
    task automatic capture(input int n, input int drop_at);
        for (int c = 0; c < n; c++) begin
            @(posedge I_clk);
            #1;
            v_s[c]   = O_vsync;
            h_s[c]   = O_href;
            b_s[c]   = O_busy;
            p_s[c]   = O_pixdata;
            f_s[c]   = O_frame_cnt;
            p16_s[c] = pix16;
            if (c == drop_at) I_en = 1'b0;
        end
    endtask

    initial begin
        int n_vs, first_vs, n_hr, first_hr, rises, overlap, dirty, n_busy, bad, bad16;
        int rise_at [0:3];
        int k;

        I_rst = 1'b1; I_en = 1'b0; I_mode = 1'b0; I_pattern = 2'd0; I_solid = 16'hF81F;
        repeat (3) @(posedge I_clk);
        #1;
        check("rst_vsync", 32'(O_vsync), 0);
        check("rst_href", 32'(O_href), 0);
        check("rst_pixdata", 32'(O_pixdata), 0);
        check("rst_frame_cnt", 32'(O_frame_cnt), 0);
        check("rst_busy", 32'(O_busy), 0);
        @(negedge I_clk) I_rst = 1'b0;

        // RAW10 horizontal ramp, single-cycle enable pulse
        @(negedge I_clk) I_en = 1'b1;
        capture(150, 0);
        n_vs = 0; first_vs = -1; n_hr = 0; first_hr = -1;
        rises = 0; overlap = 0; dirty = 0; n_busy = 0;
        for (int c = 0; c < 150; c++) begin
            if (v_s[c]) begin n_vs++; if (first_vs < 0) first_vs = c; end
            if (h_s[c]) begin n_hr++; if (first_hr < 0) first_hr = c; end
            if (c > 0 && h_s[c] && !h_s[c-1]) rises++;
            if (v_s[c] && h_s[c]) overlap++;
            if (!h_s[c] && p_s[c] != 10'd0) dirty++;
            if (b_s[c]) n_busy++;
        end
        check("hr_vsync_cycles", n_vs, 12);
        check("hr_vsync_first", first_vs, 1);
        check("hr_href_first", first_hr, 25);
        check("hr_href_cycles", n_hr, 32);
        check("hr_href_pulses", rises, 4);
        check("hr_vs_href_overlap", overlap, 0);
        check("hr_data_outside_href", dirty, 0);
        check("hr_busy_cycles", n_busy, 84);
        check("hr_busy_last", 32'(b_s[84]), 1);
        check("hr_busy_end", 32'(b_s[85]), 0);
        check("hr_frame_cnt", 32'(f_s[149]), 1);
        for (int i = 0; i < 8; i++) check($sformatf("hr_pix%0d", i), 32'(p_s[25 + i]), i);
        check("hr_line2_pix7", 32'(p_s[44]), 7);

        // RGB565 solid F81F: high byte F8, low byte 1F, each shifted up by 2
        I_mode = 1'b1; I_pattern = 2'd3;
        @(negedge I_clk) I_en = 1'b1;
        capture(150, 0);
        n_hr = 0; bad = 0; n_busy = 0;
        for (int c = 0; c < 150; c++) begin
            if (h_s[c]) n_hr++;
            if (b_s[c]) n_busy++;
        end
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 16; i++)
                if (!h_s[41 + 20*j + i] ||
                    p_s[41 + 20*j + i] != ((i % 2 == 0) ? 10'h3E0 : 10'h07C)) bad++;
        check("rgb_href_before", 32'(h_s[40]), 0);
        check("rgb_href_cycles", n_hr, 64);
        check("rgb_byte0", 32'(p_s[41]), 32'h3E0);
        check("rgb_byte1", 32'(p_s[42]), 32'h07C);
        check("rgb_href_after_line", 32'(h_s[57]), 0);
        check("rgb_alternation_errors", bad, 0);
        check("rgb_busy_cycles", n_busy, 140);
        check("rgb_frame_cnt", 32'(f_s[149]), 2);
        repeat (120) @(posedge I_clk);

        // RAW10 colour bars on both geometries
        I_mode = 1'b0; I_pattern = 2'd2;
        @(negedge I_clk) I_en = 1'b1;
        capture(150, 0);
        bad = 0; bad16 = 0;
        for (int i = 0; i < 8; i++)
            if (p_s[25 + i] != 10'(i * 128)) bad++;
        for (int i = 0; i < 16; i++)
            if (p16_s[41 + i] != 10'((i / 2) * 128)) bad16++;
        check("bars8_pix3", 32'(p_s[28]), 32'h180);
        check("bars8_errors", bad, 0);
        check("bars16_pix0", 32'(p16_s[41]), 32'h000);
        check("bars16_pix1", 32'(p16_s[42]), 32'h000);
        check("bars16_pix2", 32'(p16_s[43]), 32'h080);
        check("bars16_pix15", 32'(p16_s[56]), 32'h380);
        check("bars16_errors", bad16, 0);

        // Reset during ACTIVE, then back-to-back frames with I_en held high
        I_pattern = 2'd0;
        @(negedge I_clk) I_en = 1'b1;
        k = 0;
        while (!O_href && k < 100) begin
            @(posedge I_clk);
            #1;
            k++;
        end
        check("pre_rst_href", 32'(O_href), 1);
        I_rst = 1'b1;
        #1;
        check("async_rst_vsync", 32'(O_vsync), 0);
        check("async_rst_href", 32'(O_href), 0);
        check("async_rst_pixdata", 32'(O_pixdata), 0);
        check("async_rst_busy", 32'(O_busy), 0);
        check("async_rst_frame_cnt", 32'(O_frame_cnt), 0);
        @(posedge I_clk);
        @(negedge I_clk) I_rst = 1'b0;
        capture(270, 200);
        rises = 0; n_busy = 0;
        for (int c = 1; c < 270; c++) begin
            if (v_s[c] && !v_s[c-1]) begin
                if (rises < 4) rise_at[rises] = c;
                rises++;
            end
            if (c <= 252 && !b_s[c]) n_busy++;
        end
        check("b2b_vsync_rises", rises, 3);
        check("b2b_rise1", rise_at[0], 1);
        check("b2b_rise2", rise_at[1], 85);
        check("b2b_rise3", rise_at[2], 169);
        check("b2b_frame_cnt1", 32'(f_s[1]), 1);
        check("b2b_frame_cnt2", 32'(f_s[85]), 2);
        check("b2b_frame_cnt3", 32'(f_s[169]), 3);
        check("b2b_busy_gaps", n_busy, 0);
        check("b2b_busy_end", 32'(b_s[253]), 0);
        check("b2b_busy_stays_low", 32'(b_s[269]), 0);

        // Frame counter wrap from a preloaded 0xFFFF
        @(negedge I_clk) force dut.frame_cnt_q = 16'hFFFF;
        @(negedge I_clk) release dut.frame_cnt_q;
        @(posedge I_clk);
        #1;
        check("wrap_preload", 32'(O_frame_cnt), 32'hFFFF);
        @(negedge I_clk) I_en = 1'b1;
        @(posedge I_clk);
        #1;
        I_en = 1'b0;
        @(posedge I_clk);
        #1;
        check("wrap_frame_cnt", 32'(O_frame_cnt), 0);
        check("wrap_vsync", 32'(O_vsync), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
